axis_pkt_fifo: RTL and testbench

- Synchronous AXI-Stream FIFO for 8-bit data with tlast. It sits directly downstream of the 2:1 stream mux and consumes its m_data/m_valid/m_ready/m_last.
- Decouples mux output from the sink and absorbs back-pressure.
- Optional store-and-forward mode: output is held until a complete packet is buffered.

---
 rtl/axis_pkg.sv | 25 ++
 rtl/axis_fifo_mem.sv | 34 +++
 rtl/axis_pkt_fifo.sv | 146 ++++++++++++++
 tb/tb_axis_pkt_fifo.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream packet FIFO.
//   AXIS_DATA_W : default beat data width
//   beat_t      : one stored beat, {last, data}
//   HOLD/RELEASE: store-and-forward release state encoding
package axis_pkg;

  localparam int AXIS_DATA_W = 8;

  typedef struct packed {
    logic                   last;
    logic [AXIS_DATA_W-1:0] data;
  } beat_t;

  localparam logic [0:0] HOLD    = 1'b0;
  localparam logic [0:0] RELEASE = 1'b1;

  // Pack a beat into the {last, data} layout used by the storage array.
  function automatic beat_t make_beat(input logic last, input logic [AXIS_DATA_W-1:0] data);
    beat_t b;
    b.last = last;
    b.data = data;
    return b;
  endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Storage array for the packet FIFO: DEPTH entries of {last, data}.
// Ports:
//   clk   : write clock
//   we    : write enable, writes wdata at waddr on the rising edge
//   waddr : write address
//   wdata : {last, data} to store
//   raddr : read address
//   rdata : {last, data} at raddr, combinational (first-word-fall-through)
module axis_fifo_mem
  import axis_pkg::*;
#(
  parameter int DATA_W = AXIS_DATA_W,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W:0]          rdata
);

  logic [DATA_W:0] mem_q [DEPTH];

  // Contents are not reset: pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// Synchronous AXI-Stream FIFO with tlast, optional store-and-forward.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   s_data/s_valid/s_last/s_ready : input stream
//   m_data/m_valid/m_last/m_ready : output stream (first-word-fall-through)
//   level       : entries stored
//   pkt_count   : last beats stored
//   almost_full : level >= AFULL_TH
//   overflow    : sticky, an oversize packet forced cut-through release
module axis_pkt_fifo
  import axis_pkg::*;
#(
  parameter int DATA_W   = AXIS_DATA_W,
  parameter int DEPTH    = 16,
  parameter int PKT_MODE = 0,
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_last,
  output logic [DATA_W-1:0]      m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic [$clog2(DEPTH):0] level,
  output logic [$clog2(DEPTH):0] pkt_count,
  output logic                   almost_full,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_L = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_L = LW'(AFULL_TH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] pkt_count_q, pkt_count_d;
  logic [0:0]    state_q, state_d;
  logic          overflow_q, overflow_d;
  // Cleared by reset, set on the first edge after release; keeps s_ready
  // low and the output beat at zero while the block is held in reset.
  logic          run_q, run_d;

  logic          wr;
  logic          rd;
  logic [DATA_W:0] rd_beat;

  axis_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr),
    .waddr (wr_ptr_q),
    .wdata ({s_last, s_data}),
    .raddr (rd_ptr_q),
    .rdata (rd_beat)
  );

  // Ready depends only on the stored level: a full FIFO refuses a beat even
  // when the sink drains one in the same cycle.
  assign s_ready = run_q && (level_q != FULL_L);

  // Store-and-forward holds output until a complete packet is present, or
  // until an oversize packet has forced the release state.
  assign m_valid = (level_q != '0) &&
                   ((PKT_MODE == 0) || (pkt_count_q != '0) || (state_q == RELEASE));

  assign m_data      = run_q ? rd_beat[DATA_W-1:0] : '0;
  assign m_last      = run_q ? rd_beat[DATA_W]     : 1'b0;
  assign level       = level_q;
  assign pkt_count   = pkt_count_q;
  assign almost_full = (level_q >= AFULL_L);
  assign overflow    = overflow_q;

  assign wr = s_valid && s_ready;
  assign rd = m_valid && m_ready;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    pkt_count_d = pkt_count_q;
    state_d     = state_q;
    overflow_d  = overflow_q;
    run_d       = 1'b1;

    if (wr) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({wr, rd})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    case ({wr && s_last, rd && m_last})
      2'b10:   pkt_count_d = pkt_count_q + LW'(1);
      2'b01:   pkt_count_d = pkt_count_q - LW'(1);
      default: pkt_count_d = pkt_count_q;
    endcase

    if (PKT_MODE != 0) begin
      if (state_q == HOLD) begin
        // Full with no packet end stored: the packet cannot fit, so stream it
        // out rather than deadlock, and flag the oversize event.
        if ((level_q == FULL_L) && (pkt_count_q == '0)) begin
          state_d    = RELEASE;
          overflow_d = 1'b1;
        end
      end else if (rd && m_last) begin
        state_d = HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pkt_count_q <= '0;
      state_q     <= HOLD;
      overflow_q  <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pkt_count_q <= pkt_count_d;
      state_q     <= state_d;
      overflow_q  <= overflow_d;
      run_q       <= run_d;
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Self-checking bench: instance 0 is cut-through, instance 1 store-and-forward.
// A queue model per instance is compared against the DUT outputs every cycle,
// and directed sequences add literal expectations.
module tb_axis_pkt_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  bit   chk_on = 1'b0;

  logic [7:0] s_data [2];
  logic       s_valid [2];
  logic       s_last [2];
  logic       m_ready [2];
  logic       s_ready [2];
  logic [7:0] m_data [2];
  logic       m_valid [2];
  logic       m_last [2];
  logic [4:0] level [2];
  logic [4:0] pcnt [2];
  logic       af [2];
  logic       ovf [2];

  int n_cmp = 0;
  int n_bad = 0;

  int rx_n = 0;
  int rx_lasts = 0;
  logic [8:0] rx_prev = '0;

  always #5 clk = ~clk;

  axis_pkt_fifo #(.DATA_W(8), .DEPTH(16), .PKT_MODE(0), .AFULL_TH(14)) u_ct (
    .clk(clk), .reset(rst_n),
    .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_last(s_last[0]),
    .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_last(m_last[0]),
    .level(level[0]), .pkt_count(pcnt[0]), .almost_full(af[0]), .overflow(ovf[0])
  );

  axis_pkt_fifo #(.DATA_W(8), .DEPTH(16), .PKT_MODE(1), .AFULL_TH(14)) u_sf (
    .clk(clk), .reset(rst_n),
    .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_last(s_last[1]),
    .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_last(m_last[1]),
    .level(level[1]), .pkt_count(pcnt[1]), .almost_full(af[1]), .overflow(ovf[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of {last,data}; everything else is derived
  // from its size and the number of packet ends it holds.
  for (genvar gi = 0; gi < 2; gi++) begin : g_model
    localparam bit PM = (gi == 1);
    logic [8:0] q [$];
    bit run = 1'b0;
    bit rel = 1'b0;
    bit ovf_m = 1'b0;

    function automatic int nlast();
      int n;
      n = 0;
      foreach (q[k]) if (q[k][8]) n++;
      return n;
    endfunction

    initial begin : upd
      int nl;
      bit sr, mv, dw, dr;
      logic [8:0] fr;
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          q.delete();
          run = 1'b0;
          rel = 1'b0;
          ovf_m = 1'b0;
        end else begin
          nl = nlast();
          sr = run && (q.size() < 16);
          mv = (q.size() > 0) && (!PM || nl > 0 || rel);
          dw = sr && s_valid[gi];
          dr = mv && m_ready[gi];
          fr = (q.size() > 0) ? q[0] : 9'h0;
          if (PM && !rel && q.size() == 16 && nl == 0) begin
            rel = 1'b1;
            ovf_m = 1'b1;
          end else if (rel && dr && fr[8]) begin
            rel = 1'b0;
          end
          if (dr) void'(q.pop_front());
          if (dw) q.push_back({s_last[gi], s_data[gi]});
          run = 1'b1;
        end
      end
    end

    initial begin : cmp
      int nl;
      bit sr, mv;
      forever begin
        @(negedge clk);
        if (chk_on) begin
          nl = nlast();
          sr = run && (q.size() < 16);
          mv = (q.size() > 0) && (!PM || nl > 0 || rel);
          chk($sformatf("i%0d s_ready", gi), int'(s_ready[gi]), int'(sr));
          chk($sformatf("i%0d m_valid", gi), int'(m_valid[gi]), int'(mv));
          chk($sformatf("i%0d level", gi), int'(level[gi]), q.size());
          chk($sformatf("i%0d pkt_count", gi), int'(pcnt[gi]), nl);
          chk($sformatf("i%0d almost_full", gi), int'(af[gi]), int'(q.size() >= 14));
          chk($sformatf("i%0d overflow", gi), int'(ovf[gi]), int'(ovf_m));
          if (!run) begin
            chk($sformatf("i%0d m_data rst", gi), int'(m_data[gi]), 0);
            chk($sformatf("i%0d m_last rst", gi), int'(m_last[gi]), 0);
          end else if (mv) begin
            chk($sformatf("i%0d m_data", gi), int'(m_data[gi]), int'(q[0][7:0]));
            chk($sformatf("i%0d m_last", gi), int'(m_last[gi]), int'(q[0][8]));
          end
        end
      end
    end
  end

  // Beats handed to the sink on instance 1, captured before the edge that takes them.
  initial forever begin
    @(negedge clk);
    if (rst_n && m_valid[1] && m_ready[1]) begin
      rx_n++;
      if (m_last[1]) rx_lasts++;
      rx_prev = {m_last[1], m_data[1]};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and wait (bounded) until it is accepted; returns at edge+1.
  task automatic push(input int i, input logic [7:0] d, input logic l);
    int n;
    bit ok;
    s_data[i] = d;
    s_last[i] = l;
    s_valid[i] = 1'b1;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 64) begin
      ok = s_ready[i];
      step();
      n++;
    end
    s_valid[i] = 1'b0;
    s_last[i] = 1'b0;
    chk($sformatf("i%0d push 0x%0h accepted", i, d), int'(ok), 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k;
    for (int i = 0; i < 2; i++) begin
      s_data[i] = '0;
      s_valid[i] = 1'b0;
      s_last[i] = 1'b0;
      m_ready[i] = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1 chk_on = 1'b1;
    #19 rst_n = 1'b1;
    chk("reset s_ready before edge", int'(s_ready[0]), 0);
    step();
    chk("s_ready after first edge", int'(s_ready[0]), 1);
    chk("level after reset", int'(level[0]), 0);

    // Cut-through: each beat visible one cycle after its write.
    m_ready[0] = 1'b1;
    push(0, 8'h11, 1'b0); chk("t1 data 11", int'(m_data[0]), 'h11); chk("t1 last 11", int'(m_last[0]), 0);
    push(0, 8'h22, 1'b0); chk("t1 data 22", int'(m_data[0]), 'h22);
    push(0, 8'h33, 1'b0); chk("t1 data 33", int'(m_data[0]), 'h33);
    push(0, 8'h44, 1'b1); chk("t1 data 44", int'(m_data[0]), 'h44); chk("t1 last 44", int'(m_last[0]), 1);
    step();
    chk("t1 level 0", int'(level[0]), 0);
    $display("t1 cut-through 4 beats done");

    // Fill to DEPTH with the sink stalled, then drain and wrap.
    m_ready[0] = 1'b0;
    for (k = 0; k < 16; k++) begin
      push(0, 8'(8'h80 + k), k == 15);
      chk($sformatf("t2 level %0d", k + 1), int'(level[0]), k + 1);
      chk($sformatf("t2 afull %0d", k + 1), int'(af[0]), int'(k + 1 >= 14));
    end
    chk("t2 s_ready full", int'(s_ready[0]), 0);
    m_ready[0] = 1'b1;
    for (k = 0; k < 16; k++) begin
      chk($sformatf("t2 drain %0d", k), int'(m_data[0]), 'h80 + k);
      step();
    end
    chk("t2 drained", int'(level[0]), 0);
    for (k = 0; k < 16; k++) begin
      push(0, 8'(8'hA0 + k), k == 15);
      chk($sformatf("t2 wrap %0d", k), int'(m_data[0]), 'hA0 + k);
    end
    step();
    $display("t2 full/drain/wrap done");

    // Store-and-forward: nothing leaves until the packet end arrives.
    m_ready[1] = 1'b1;
    for (k = 1; k <= 3; k++) begin
      push(1, 8'(k), 1'b0);
      chk($sformatf("t3 held %0d", k), int'(m_valid[1]), 0);
    end
    push(1, 8'h04, 1'b1);
    chk("t3 m_valid", int'(m_valid[1]), 1);
    chk("t3 pkt_count", int'(pcnt[1]), 1);
    for (k = 1; k <= 4; k++) begin
      chk($sformatf("t3 out %0d", k), int'(m_data[1]), k);
      step();
    end
    chk("t3 pkt_count 0", int'(pcnt[1]), 0);
    chk("t3 level 0", int'(level[1]), 0);
    $display("t3 store-and-forward 4 beats done");

    // Oversize packet forces release.
    rx_n = 0;
    rx_lasts = 0;
    for (k = 0; k < 20; k++) begin
      push(1, 8'(8'h40 + k), k == 19);
      if (k == 15) begin
        chk("t4 level 16", int'(level[1]), 16);
        chk("t4 held at 16", int'(m_valid[1]), 0);
      end
    end
    chk("t4 overflow", int'(ovf[1]), 1);
    k = 0;
    while (level[1] != 0 && k < 64) begin
      step();
      k++;
    end
    chk("t4 drained in time", int'(k < 64), 1);
    chk("t4 rx count", rx_n, 20);
    chk("t4 rx lasts", rx_lasts, 1);
    chk("t4 final beat", int'(rx_prev), 'h153);
    push(1, 8'h60, 1'b0);
    push(1, 8'h61, 1'b0);
    step();
    chk("t4 back to hold", int'(m_valid[1]), 0);
    push(1, 8'h62, 1'b1);
    repeat (5) step();
    $display("t4 oversize release done");

    // Simultaneous read and write at level 5, both beats ending packets.
    m_ready[1] = 1'b0;
    for (k = 0; k < 5; k++) push(1, 8'(8'h70 + k), 1'b1);
    chk("t5 level pre", int'(level[1]), 5);
    chk("t5 pkt pre", int'(pcnt[1]), 5);
    m_ready[1] = 1'b1;
    s_data[1] = 8'h75;
    s_last[1] = 1'b1;
    s_valid[1] = 1'b1;
    step();
    m_ready[1] = 1'b0;
    s_valid[1] = 1'b0;
    s_last[1] = 1'b0;
    chk("t5 level", int'(level[1]), 5);
    chk("t5 pkt_count", int'(pcnt[1]), 5);
    chk("t5 head", int'(m_data[1]), 'h71);
    m_ready[1] = 1'b1;
    repeat (8) step();
    chk("t5 drained", int'(level[1]), 0);
    $display("t5 simultaneous rd/wr done");

    // Reset in the middle of a packet.
    m_ready[0] = 1'b0;
    for (k = 0; k < 7; k++) push(0, 8'(8'hB0 + k), 1'b0);
    chk("t6 level 7", int'(level[0]), 7);
    #3 rst_n = 1'b0;
    #1;
    chk("t6 rst m_valid", int'(m_valid[0]), 0);
    chk("t6 rst s_ready", int'(s_ready[0]), 0);
    chk("t6 rst level", int'(level[0]), 0);
    chk("t6 rst pkt", int'(pcnt[0]), 0);
    chk("t6 rst m_data", int'(m_data[0]), 0);
    chk("t6 rst overflow", int'(ovf[1]), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    chk("t6 s_ready after release", int'(s_ready[0]), 1);
    m_ready[0] = 1'b1;
    push(0, 8'hC1, 1'b0); chk("t6 data C1", int'(m_data[0]), 'hC1);
    push(0, 8'hC2, 1'b1); chk("t6 data C2", int'(m_data[0]), 'hC2); chk("t6 last C2", int'(m_last[0]), 1);
    m_ready[1] = 1'b1;
    push(1, 8'hD1, 1'b0); chk("t6 sf held", int'(m_valid[1]), 0);
    push(1, 8'hD2, 1'b1); chk("t6 sf D1", int'(m_data[1]), 'hD1);
    step();
    chk("t6 sf D2", int'(m_data[1]), 'hD2);
    chk("t6 sf last", int'(m_last[1]), 1);
    repeat (3) step();
    $display("t6 reset mid-packet done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
